// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
//   Shared definitions for the FIFO-fed UART transmitter: parity mode
//   encodings, the transmit FSM state encoding and the parity helper.
//   No ports; imported by uart_tx_fifo.
package uart_tx_fifo_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Encoding reflects what is currently being driven on the line.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    // data_xor is the XOR reduction of the data word. Even parity makes the
    // total count of ones even, so the parity bit equals the reduction;
    // odd parity inverts it.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with synchronous active-high reset and show-ahead read
//   (rd_data presents the oldest entry whenever empty is low).
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset, empties the FIFO
//   wr_en    in   write request, ignored when full
//   wr_data  in   WIDTH-bit write data
//   rd_en    in   read request, ignored when empty
//   rd_data  out  WIDTH-bit oldest entry
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   count    out  entries held
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter fed from a valid/ready byte stream through an internal
//   FIFO. Frames are serialised LSB-first with configurable data width,
//   parity and stop bits; every line transition is paced by baud_tick.
//
//   state  | meaning
//   IDLE   | line idle high, waiting for a tick with data in the FIFO
//   START  | start bit (0) on the line
//   DATA   | data bit bit_cnt on the line
//   PAR    | parity bit on the line
//   STOP   | stop bit stop_cnt on the line
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset, aborts frame, empties FIFO
//   baud_tick   in   one-cycle pulse per bit period
//   in_data     in   DATA_BITS word, captured at push
//   in_valid    in   in_data valid
//   in_ready    out  FIFO can accept (not full)
//   tx          out  registered UART line, idle high
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse at the end of the last stop bit
//   fifo_count  out  entries held in the FIFO
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            baud_tick,
    input  logic [DATA_BITS-1:0]            in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            tx,
    output logic                            busy,
    output logic                            frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t              state;
    logic [DATA_BITS-1:0]   shift;
    logic [3:0]             bit_cnt;
    logic                   stop_cnt;
    logic                   par_bit;
    logic [DATA_BITS-1:0]   fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   last_stop;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign busy      = (state != ST_IDLE);

    // Pop is only possible on a tick that starts a frame: from IDLE, or
    // straight out of the last stop bit for back-to-back frames. Empty is a
    // registered flag, so a freshly pushed word is never popped in its own cycle.
    assign pop = baud_tick && !fifo_empty &&
                 ((state == ST_IDLE) || (state == ST_STOP && last_stop));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            frame_done <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift   <= fifo_rd_data;
                        par_bit <= parity_bit(^fifo_rd_data, PARITY);
                        tx      <= 1'b0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            if (PARITY != PARITY_NONE) begin
                                tx    <= par_bit;
                                state <= ST_PAR;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= ST_STOP;
                            end
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                ST_PAR: begin
                    if (baud_tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (last_stop) begin
                            frame_done <= 1'b1;
                            if (pop) begin
                                shift   <= fifo_rd_data;
                                par_bit <= parity_bit(^fifo_rd_data, PARITY);
                                tx      <= 1'b0;
                                state   <= ST_START;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                // Recover from a corrupted encoding without waiting for a tick.
                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. Four instances share clk, rst and
//   baud_tick: u0 8N1, u1 8E1, u2 8O1, u3 7N2. baud_tick pulses every 16 clks.
//   Each tick-driven run records tx and busy right after every tick edge,
//   bit i of the record being the value after tick i.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        baud_tick;
    logic [7:0]  din0, din1, din2;
    logic [6:0]  din3;
    logic [3:0]  vld;
    wire  [3:0]  rdy, txv, bsy, fd;
    wire  [11:0] cnt_all;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt [4];

    logic [31:0] txb, bsb;
    logic [31:0] txb2, bsb2;
    int          fd_base [4];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(din0), .in_valid(vld[0]),
        .in_ready(rdy[0]), .tx(txv[0]), .busy(bsy[0]), .frame_done(fd[0]),
        .fifo_count(cnt_all[2:0]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(din1), .in_valid(vld[1]),
        .in_ready(rdy[1]), .tx(txv[1]), .busy(bsy[1]), .frame_done(fd[1]),
        .fifo_count(cnt_all[5:3]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(din2), .in_valid(vld[2]),
        .in_ready(rdy[2]), .tx(txv[2]), .busy(bsy[2]), .frame_done(fd[2]),
        .fifo_count(cnt_all[8:6]));
    uart_tx_fifo #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(din3), .in_valid(vld[3]),
        .in_ready(rdy[3]), .tx(txv[3]), .busy(bsy[3]), .frame_done(fd[3]),
        .fifo_count(cnt_all[11:9]));

    always @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (fd[d] === 1'b1) fd_cnt[d] = fd_cnt[d] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; a word offered with valid high is dropped once it was accepted.
    task automatic cyc();
        logic [3:0] acc;
        acc = vld & rdy;
        @(posedge clk);
        #1;
        vld = vld & ~acc;
    endtask

    task automatic push(input int d, input logic [7:0] w);
        case (d)
            0: din0 = w;
            1: din1 = w;
            2: din2 = w;
            default: din3 = w[6:0];
        endcase
        vld[d] = 1'b1;
        cyc();
    endtask

    task automatic run_ticks(input int d, input int n,
                             output logic [31:0] tb_o, output logic [31:0] bb_o);
        tb_o = '0;
        bb_o = '0;
        for (int i = 0; i < n; i++) begin
            baud_tick = 1'b1;
            cyc();
            baud_tick = 1'b0;
            tb_o[i] = txv[d];
            bb_o[i] = bsy[d];
            repeat (15) cyc();
        end
    endtask

    function automatic logic [2:0] cnt(input int d);
        return cnt_all[3*d +: 3];
    endfunction

    logic [7:0] words4 [5] = '{8'h01, 8'h80, 8'hA5, 8'h3C, 8'hFF};
    logic [9:0] frames4 [5] = '{10'h202, 10'h300, 10'h34A, 10'h278, 10'h3FE};

    initial begin
        for (int d = 0; d < 4; d++) fd_cnt[d] = 0;
        rst = 1'b1;
        baud_tick = 1'b0;
        vld = '0;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // reset state on every instance
        chk("reset_tx",     {28'd0, txv}, 32'hF);
        chk("reset_busy",   {28'd0, bsy}, 32'h0);
        chk("reset_ready",  {28'd0, rdy}, 32'hF);
        chk("reset_fd",     {28'd0, fd},  32'h0);
        chk("reset_count",  {20'd0, cnt_all}, 32'h0);

        // 8N1 frame of 0x50
        fd_base[0] = fd_cnt[0];
        push(0, 8'h50);
        chk("t1_count", {29'd0, cnt(0)}, 32'd1);
        chk("t1_busy_pre", {31'd0, bsy[0]}, 32'd0);
        run_ticks(0, 10, txb, bsb);
        chk("t1_tx_bits", txb, 32'h2A0);
        chk("t1_busy", bsb, 32'h3FF);
        chk("t1_fd_early", fd_cnt[0] - fd_base[0], 32'd0);
        run_ticks(0, 1, txb, bsb);
        chk("t1_idle_tx", txb, 32'h1);
        chk("t1_idle_busy", bsb, 32'h0);
        chk("t1_fd", fd_cnt[0] - fd_base[0], 32'd1);

        // parity: 0x4F on even and odd instances in parallel
        fd_base[1] = fd_cnt[1];
        fd_base[2] = fd_cnt[2];
        din1 = 8'h4F; din2 = 8'h4F;
        vld[1] = 1'b1; vld[2] = 1'b1;
        cyc();
        for (int i = 0; i < 12; i++) begin
            baud_tick = 1'b1;
            cyc();
            baud_tick = 1'b0;
            txb[i]  = txv[1];
            bsb[i]  = bsy[1];
            txb2[i] = txv[2];
            bsb2[i] = bsy[2];
            repeat (15) cyc();
        end
        chk("t2_even_bits", {20'd0, txb[11:0]}, 32'hE9E);
        chk("t2_even_busy", {20'd0, bsb[11:0]}, 32'h7FF);
        chk("t2_odd_bits",  {20'd0, txb2[11:0]}, 32'hC9E);
        chk("t2_odd_busy",  {20'd0, bsb2[11:0]}, 32'h7FF);
        chk("t2_even_fd", fd_cnt[1] - fd_base[1], 32'd1);
        chk("t2_odd_fd",  fd_cnt[2] - fd_base[2], 32'd1);

        // 7N2 back-to-back frames
        fd_base[3] = fd_cnt[3];
        push(3, 8'h35);
        push(3, 8'h4A);
        chk("t3_count", {29'd0, cnt(3)}, 32'd2);
        run_ticks(3, 21, txb, bsb);
        chk("t3_tx_bits", txb, 32'h1E536A);
        chk("t3_busy", bsb, 32'hFFFFF);
        chk("t3_fd", fd_cnt[3] - fd_base[3], 32'd2);

        // fill to full with no ticks, fifth word held off, then drain in order
        fd_base[0] = fd_cnt[0];
        for (int i = 0; i < 4; i++) push(0, words4[i]);
        chk("t4_full_count", {29'd0, cnt(0)}, 32'd4);
        chk("t4_full_ready", {31'd0, rdy[0]}, 32'd0);
        din0 = words4[4];
        vld[0] = 1'b1;
        repeat (5) cyc();
        chk("t4_held_count", {29'd0, cnt(0)}, 32'd4);
        chk("t4_held_busy", {31'd0, bsy[0]}, 32'd0);
        for (int f = 0; f < 5; f++) begin
            run_ticks(0, 10, txb, bsb);
            chk($sformatf("t4_frame%0d", f), txb, {22'd0, frames4[f]});
            chk($sformatf("t4_busy%0d", f), bsb, 32'h3FF);
            if (f == 0) chk("t4_refill_count", {29'd0, cnt(0)}, 32'd4);
        end
        run_ticks(0, 1, txb, bsb);
        chk("t4_idle_tx", txb, 32'h1);
        chk("t4_fd", fd_cnt[0] - fd_base[0], 32'd5);
        chk("t4_empty", {29'd0, cnt(0)}, 32'd0);

        // reset mid-DATA
        push(0, 8'h5A);
        push(0, 8'h11);
        run_ticks(0, 4, txb, bsb);
        chk("t5_pre_tx", {31'd0, txb[3]}, 32'd0);
        chk("t5_pre_count", {29'd0, cnt(0)}, 32'd1);
        fd_base[0] = fd_cnt[0];
        rst = 1'b1;
        cyc();
        chk("t5_rst_tx",    {31'd0, txv[0]}, 32'd1);
        chk("t5_rst_busy",  {31'd0, bsy[0]}, 32'd0);
        chk("t5_rst_count", {29'd0, cnt(0)}, 32'd0);
        chk("t5_rst_ready", {31'd0, rdy[0]}, 32'd1);
        rst = 1'b0;
        cyc();
        run_ticks(0, 12, txb, bsb);
        chk("t5_quiet_tx", txb, 32'hFFF);
        chk("t5_quiet_busy", bsb, 32'h0);
        chk("t5_no_fd", fd_cnt[0] - fd_base[0], 32'd0);
        push(0, 8'hC3);
        run_ticks(0, 11, txb, bsb);
        chk("t5_clean_frame", txb, 32'h786);
        chk("t5_clean_fd", fd_cnt[0] - fd_base[0], 32'd1);

        // push into empty FIFO with a coincident tick
        din0 = 8'h96;
        vld[0] = 1'b1;
        baud_tick = 1'b1;
        cyc();
        baud_tick = 1'b0;
        chk("t6_same_tx",    {31'd0, txv[0]}, 32'd1);
        chk("t6_same_busy",  {31'd0, bsy[0]}, 32'd0);
        chk("t6_same_count", {29'd0, cnt(0)}, 32'd1);
        repeat (15) cyc();
        chk("t6_wait_busy",  {31'd0, bsy[0]}, 32'd0);
        run_ticks(0, 11, txb, bsb);
        chk("t6_frame", txb, 32'h72C);
        chk("t6_busy", bsb, 32'h3FF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
